// File: rtl/mac_array_seq.sv
// Sequencer for the 2x2 time-multiplexed MAC array: one NxN matrix-vector
// product per start, executed as N/4 row-tile passes of clear/feed/drain/store.
module mac_array_seq #(
    parameter int          N         = 8,
    parameter int          NUM_ACC   = 8,
    parameter int          PIPE_LAT  = 2,
    parameter logic [2:0]  VC_STREAM = 3'b001,
    parameter int          COL_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             feed_ready,
    output logic             busy,
    output logic             done,
    output logic [COL_W-1:0] col_idx,
    output logic [2:0]       row_tile,
    output logic [11:0]      valid_ctrl,
    output logic [3:0]       clear,
    output logic [3:0]       valid_weight_in,
    output logic [2:0]       acc_sel_tile1,
    output logic [2:0]       acc_sel_tile2,
    output logic             res_valid,
    output logic [COL_W:0]   res_row_base
);

    localparam int               DW        = $clog2(PIPE_LAT + 2);
    localparam logic [2:0]       LAST_TILE = 3'(N / 4 - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(N - 1);

    generate
        if ((N % 4) != 0 || (N / 4) > NUM_ACC || NUM_ACC > 8) begin : g_bad_cfg
            $error("mac_array_seq: unsupported N/NUM_ACC combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;

    // row_tile is already 0 in IDLE, so the acc_sel outputs stay registered copies
    assign acc_sel_tile1 = row_tile;
    assign acc_sel_tile2 = row_tile;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            col_idx         <= '0;
            row_tile        <= '0;
            valid_ctrl      <= '0;
            clear           <= '0;
            valid_weight_in <= '0;
            res_valid       <= 1'b0;
            res_row_base    <= '0;
        end else begin
            clear           <= '0;
            valid_weight_in <= '0;
            valid_ctrl      <= '0;
            res_valid       <= 1'b0;
            res_row_base    <= '0;
            done            <= 1'b0;

            if (abort) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                col_idx   <= '0;
                row_tile  <= '0;
                drain_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_CLEAR;
                            busy     <= 1'b1;
                            clear    <= '1;
                            row_tile <= '0;
                            col_idx  <= '0;
                        end
                    end
                    S_CLEAR: begin
                        state <= S_FEED;
                        if (feed_ready) begin
                            valid_weight_in <= '1;
                            valid_ctrl      <= {4{VC_STREAM}};
                        end
                    end
                    S_FEED: begin
                        // valid_weight_in marks the column accepted this cycle;
                        // feed_ready is registered into next cycle's valids
                        if (valid_weight_in[0] && col_idx == LAST_COL) begin
                            if (PIPE_LAT == 0) begin
                                state        <= S_STORE;
                                res_valid    <= 1'b1;
                                res_row_base <= (COL_W+1)'({row_tile, 2'b00});
                            end else begin
                                state     <= S_DRAIN;
                                drain_cnt <= DW'(PIPE_LAT);
                            end
                        end else begin
                            if (valid_weight_in[0])
                                col_idx <= col_idx + 1'b1;
                            if (feed_ready) begin
                                valid_weight_in <= '1;
                                valid_ctrl      <= {4{VC_STREAM}};
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == DW'(1)) begin
                            state        <= S_STORE;
                            res_valid    <= 1'b1;
                            res_row_base <= (COL_W+1)'({row_tile, 2'b00});
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    S_STORE: begin
                        if (row_tile == LAST_TILE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_CLEAR;
                            row_tile <= row_tile + 1'b1;
                            col_idx  <= '0;
                            clear    <= '1;
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        row_tile <= '0;
                        col_idx  <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// Self-checking bench for mac_array_seq: pass-level behavioural model compared
// every cycle, plus directed timing, stall, abort, start-while-busy and reset runs.
module tb_mac_array_seq;

    localparam int N        = 8;
    localparam int NUM_ACC  = 8;
    localparam int PIPE_LAT = 2;
    localparam int COL_W    = $clog2(N);

    logic             clk = 1'b0;
    logic             rst, start, abort, feed_ready;
    logic             busy, done, res_valid;
    logic [COL_W-1:0] col_idx;
    logic [2:0]       row_tile, acc_sel_tile1, acc_sel_tile2;
    logic [11:0]      valid_ctrl;
    logic [3:0]       clear, valid_weight_in;
    logic [COL_W:0]   res_row_base;

    always #5 clk = ~clk;

    mac_array_seq #(
        .N(N), .NUM_ACC(NUM_ACC), .PIPE_LAT(PIPE_LAT), .VC_STREAM(3'b001)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .feed_ready(feed_ready),
        .busy(busy), .done(done), .col_idx(col_idx), .row_tile(row_tile),
        .valid_ctrl(valid_ctrl), .clear(clear), .valid_weight_in(valid_weight_in),
        .acc_sel_tile1(acc_sel_tile1), .acc_sel_tile2(acc_sel_tile2),
        .res_valid(res_valid), .res_row_base(res_row_base)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a run is a sequence of passes; within a pass, t counts cycles since
    // the clear cycle, acc counts accepted columns, last is t of the final column.
    bit m_busy, m_done, fr_q;
    int m_pass, m_t, m_acc, m_last;
    int cyc = 0;
    int t0 = 0;
    int res_q[$];
    int done_q[$];

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; fr_q = 0;
            m_pass = 0; m_t = 0; m_acc = 0; m_last = 0;
        end else begin
            if (abort) begin
                m_busy = 0; m_done = 0; m_pass = 0; m_t = 0; m_acc = 0;
            end else if (m_done) begin
                m_done = 0; m_busy = 0; m_pass = 0; m_acc = 0; m_t = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_pass = 0; m_t = 0; m_acc = 0; m_last = 0;
                end
            end else begin
                bit v, st;
                v  = (m_t >= 1) && (m_acc < N) && fr_q;
                st = (m_acc == N) && (m_t == m_last + PIPE_LAT + 1);
                if (st) begin
                    if (m_pass == N/4 - 1) m_done = 1;
                    else begin m_pass++; m_t = 0; m_acc = 0; end
                end else begin
                    if (v) begin
                        m_acc++;
                        if (m_acc == N) m_last = m_t;
                    end
                    m_t++;
                end
            end
            fr_q = feed_ready;
        end
    end

    always @(negedge clk) begin
        bit act, e_valid, e_res;
        int e_col;
        act     = m_busy && !m_done;
        e_valid = act && (m_t >= 1) && (m_acc < N) && fr_q;
        e_res   = act && (m_acc == N) && (m_t == m_last + PIPE_LAT + 1);
        e_col   = !m_busy ? 0 : (m_acc >= N ? N-1 : m_acc);
        chk("busy",       busy,            m_busy);
        chk("done",       done,            m_done);
        chk("clear",      clear,           (act && m_t == 0) ? 15 : 0);
        chk("vwi",        valid_weight_in, e_valid ? 15 : 0);
        chk("valid_ctrl", valid_ctrl,      e_valid ? 12'h249 : 0);
        chk("col_idx",    col_idx,         e_col);
        chk("row_tile",   row_tile,        m_busy ? m_pass : 0);
        chk("acc_sel1",   acc_sel_tile1,   m_busy ? m_pass : 0);
        chk("acc_sel2",   acc_sel_tile2,   m_busy ? m_pass : 0);
        chk("res_valid",  res_valid,       e_res);
        chk("res_base",   res_row_base,    e_res ? 4*m_pass : 0);
        if (res_valid) res_q.push_back(cyc - t0);
        if (done)      done_q.push_back(cyc - t0);
    end

    task automatic wait_done(input string name, input bit stall);
        int sc;
        bit did;
        sc = 0; did = 0;
        for (int i = 0; i < 300 && done_q.size() == 0; i++) begin
            if (sc > 0) begin
                sc--;
                if (sc == 2) begin
                    chk("stall_col", col_idx, 5);
                    chk("stall_vwi", valid_weight_in, 0);
                end
                if (sc == 0) feed_ready = 1;
            end else if (stall && !did && m_pass == 0 && col_idx == 4 && valid_weight_in == 4'hF) begin
                feed_ready = 0; sc = 3; did = 1;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (done_q.size() == 0) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_product(input string name, input bit stall,
                               input int r0, input int r1, input int d);
        res_q.delete(); done_q.delete();
        t0 = cyc; start = 1;
        @(negedge clk);
        start = 0;
        wait_done(name, stall);
        chk({name, "_nres"},  res_q.size(), 2);
        chk({name, "_res0"},  res_q.size() > 0 ? res_q[0] : -1, r0);
        chk({name, "_res1"},  res_q.size() > 1 ? res_q[1] : -1, r1);
        chk({name, "_done"},  done_q.size() > 0 ? done_q[0] : -1, d);
    endtask

    initial begin
        rst = 0; start = 0; abort = 0; feed_ready = 1;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_col",  col_idx, 0);
        chk("rst_base", res_row_base, 0);

        run_product("plain", 0, 12, 24, 25);
        repeat (3) @(negedge clk);
        run_product("stall", 1, 15, 27, 28);
        repeat (3) @(negedge clk);

        // abort in pass 1 at column 3
        t0 = cyc; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 300 && !(m_busy && !m_done && m_pass == 1 && m_acc == 3 && m_t >= 1); i++)
            @(negedge clk);
        if (!(m_pass == 1 && m_acc == 3)) chk("abort_reach_timeout", 0, 1);
        res_q.delete(); done_q.delete();
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_row",  row_tile, 0);
        repeat (30) @(negedge clk);
        chk("abort_nres",  res_q.size(), 0);
        chk("abort_ndone", done_q.size(), 0);
        run_product("after_abort", 0, 12, 24, 25);

        // start held high, then pulsed again while busy
        res_q.delete(); done_q.delete();
        t0 = cyc; start = 1;
        repeat (12) @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done("held", 0);
        repeat (6) @(negedge clk);
        chk("held_ndone", done_q.size(), 1);
        chk("held_done",  done_q.size() > 0 ? done_q[0] : -1, 25);
        chk("held_idle",  busy, 0);

        // async reset in the middle of DRAIN
        start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 300 && !(m_busy && !m_done && m_acc == N && m_t <= m_last + PIPE_LAT); i++)
            @(negedge clk);
        if (m_acc != N) chk("drain_reach_timeout", 0, 1);
        #2 rst = 1;
        #1;
        chk("arst_busy",  busy, 0);
        chk("arst_col",   col_idx, 0);
        chk("arst_row",   row_tile, 0);
        chk("arst_vc",    valid_ctrl, 0);
        chk("arst_res",   res_valid, 0);
        @(negedge clk);
        rst = 0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            feed_ready = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 15) == 0);
            abort      = ($urandom_range(0, 249) == 0);
        end
        start = 0; abort = 0; feed_ready = 1;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
